// File: rtl/enc_round_sequencer.sv
// Multi-round sequencer around the 8-bit encryption round function.
// Accepts a byte/key pair, runs ROUNDS rounds, then presents the ciphertext on a valid/ready port.
module enc_round_sequencer #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] number,
  input  logic [7:0] key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] enc_number,
  output logic       busy,
  output logic [3:0] round_idx
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned HW = DW / 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  logic [1:0]    state, state_nxt;
  logic [DW-1:0] st, st_nxt;
  logic [DW-1:0] rk, rk_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] enc_nxt;

  logic [DW-1:0] e;
  logic [DW-1:0] x;
  logic [HW-1:0] s;
  logic [DW-1:0] r;

  // Single round-function instance; the nibble sum drops its carry.
  always_comb begin
    e = {st[3], st[0], st[1], st[2], st[1], st[3], st[2], st[0]};
    x = e ^ rk;
    s = x[7:4] + x[3:0] + {3'b000, rk[0]};
    r = {s ^ st[7:4], st[3:0]};
  end

  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    rk_nxt    = rk;
    cnt_nxt   = cnt;
    enc_nxt   = enc_number;
    case (state)
      IDLE: begin
        if (in_valid) begin
          st_nxt    = number;
          rk_nxt    = key;
          cnt_nxt   = '0;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        // Final round publishes R unswapped; earlier rounds swap halves and rotate the key.
        if (cnt == LAST) begin
          enc_nxt   = r;
          state_nxt = DONE;
        end else begin
          st_nxt  = {r[3:0], r[7:4]};
          rk_nxt  = {rk[6:0], rk[7]};
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      st         <= '0;
      rk         <= '0;
      cnt        <= '0;
      enc_number <= '0;
    end else begin
      state      <= state_nxt;
      st         <= st_nxt;
      rk         <= rk_nxt;
      cnt        <= cnt_nxt;
      enc_number <= enc_nxt;
    end
  end

  // Status decodes come only from registered state, never from the handshake inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ROUND) || (state == DONE);
  assign round_idx = (state == ROUND) ? cnt : '0;

endmodule

// File: tb/tb_enc_round_sequencer.sv
// Scoreboard bench for enc_round_sequencer at ROUNDS = 1, 2 and 4.
module tb_enc_round_sequencer;

  logic       clock;
  logic       reset;
  logic [7:0] number;
  logic [7:0] key;
  logic       out_ready;
  logic       iv1, iv2, iv4;
  logic       ir1, ir2, ir4;
  logic       ov1, ov2, ov4;
  logic       b1, b2, b4;
  logic [7:0] en1, en2, en4;
  logic [3:0] ri1, ri2, ri4;

  int passed = 0;
  int total  = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q4[$];

  logic [7:0] tn[8] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5E, 8'hD2, 8'h17, 8'hA9};
  logic [7:0] tk[8] = '{8'h01, 8'h80, 8'hC3, 8'h7E, 8'h2B, 8'h99, 8'hF0, 8'h46};

  enc_round_sequencer #(.ROUNDS(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(iv1), .in_ready(ir1), .number(number), .key(key),
    .out_valid(ov1), .out_ready(out_ready), .enc_number(en1), .busy(b1), .round_idx(ri1));
  enc_round_sequencer #(.ROUNDS(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(iv2), .in_ready(ir2), .number(number), .key(key),
    .out_valid(ov2), .out_ready(out_ready), .enc_number(en2), .busy(b2), .round_idx(ri2));
  enc_round_sequencer #(.ROUNDS(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(iv4), .in_ready(ir4), .number(number), .key(key),
    .out_valid(ov4), .out_ready(out_ready), .enc_number(en4), .busy(b4), .round_idx(ri4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] rfn(logic [7:0] n, logic [7:0] k);
    logic [7:0] e, x;
    logic [3:0] s;
    e = {n[3], n[0], n[1], n[2], n[1], n[3], n[2], n[0]};
    x = e ^ k;
    s = x[7:4] + x[3:0] + {3'b000, k[0]};
    return {s ^ n[7:4], n[3:0]};
  endfunction

  function automatic logic [7:0] model(logic [7:0] n0, logic [7:0] k0, int rounds);
    logic [7:0] n, k, r;
    n = n0; k = k0; r = '0;
    for (int i = 0; i < rounds; i++) begin
      r = rfn(n, k);
      n = {r[3:0], r[7:4]};
      k = {k[6:0], k[7]};
    end
    return r;
  endfunction

  function automatic logic sel_ov(int w);
    case (w) 1: return ov1; 2: return ov2; default: return ov4; endcase
  endfunction
  function automatic logic sel_ir(int w);
    case (w) 1: return ir1; 2: return ir2; default: return ir4; endcase
  endfunction
  function automatic logic sel_busy(int w);
    case (w) 1: return b1; 2: return b2; default: return b4; endcase
  endfunction
  function automatic logic [3:0] sel_ri(int w);
    case (w) 1: return ri1; 2: return ri2; default: return ri4; endcase
  endfunction

  task automatic set_iv(int w, logic v);
    case (w) 1: iv1 = v; 2: iv2 = v; default: iv4 = v; endcase
  endtask
  task automatic push(int w, logic [7:0] v);
    case (w) 1: q1.push_back(v); 2: q2.push_back(v); default: q4.push_back(v); endcase
  endtask

  // Issue one transaction, track round_idx each cycle and measure latency up to out_valid.
  task automatic send(int w, logic [7:0] n, logic [7:0] k, int rounds, logic [7:0] exp);
    int lat;
    lat = 0;
    check($sformatf("r%0d_ready_before_send", w), 32'(sel_ir(w)), 32'd1);
    number = n; key = k;
    set_iv(w, 1'b1);
    push(w, exp);
    @(posedge clock); #1;
    set_iv(w, 1'b0);
    while (!sel_ov(w) && lat < 40) begin
      check($sformatf("r%0d_round_idx", w), 32'(sel_ri(w)), 32'(lat));
      check($sformatf("r%0d_busy_round", w), 32'(sel_busy(w)), 32'd1);
      @(posedge clock); #1;
      lat++;
    end
    check($sformatf("r%0d_latency", w), 32'(lat), 32'(rounds));
    check($sformatf("r%0d_ready_in_done", w), 32'(sel_ir(w)), 32'd0);
    check($sformatf("r%0d_round_idx_done", w), 32'(sel_ri(w)), 32'd0);
  endtask

  // Monitor: pop expected results on every output handshake.
  always @(negedge clock) begin
    if (!reset && out_ready) begin
      if (ov1) begin
        if (q1.size() == 0) check("r1_extra_output", 32'(q1.size()), 32'd1);
        else check("r1_result", 32'(en1), 32'(q1.pop_front()));
      end
      if (ov2) begin
        if (q2.size() == 0) check("r2_extra_output", 32'(q2.size()), 32'd1);
        else check("r2_result", 32'(en2), 32'(q2.pop_front()));
      end
      if (ov4) begin
        if (q4.size() == 0) check("r4_extra_output", 32'(q4.size()), 32'd1);
        else check("r4_result", 32'(en4), 32'(q4.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    logic [7:0] hold;
    int cyc, last, idx, k;

    reset = 1'b1; out_ready = 1'b1; number = '0; key = '0;
    iv1 = 1'b0; iv2 = 1'b0; iv4 = 1'b0;
    #1;
    check("reset_in_ready", 32'(ir4), 32'd1);
    check("reset_out_valid", 32'(ov4), 32'd0);
    check("reset_busy", 32'(b4), 32'd0);
    check("reset_round_idx", 32'(ri4), 32'd0);
    check("reset_enc_number", 32'(en4), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Single-round configuration with hand-computed results.
    send(1, 8'h46, 8'h93, 1, 8'h06);
    @(posedge clock); #1;
    send(1, 8'hC9, 8'hAC, 1, 8'h39);
    @(posedge clock); #1;

    // Two rounds: intermediate state is left untouched by the final round.
    send(2, 8'h46, 8'h93, 2, 8'hC0);
    check("r2_st_after_round0", 32'(dut2.st), 32'h60);
    check("r2_rk_after_round0", 32'(dut2.rk), 32'h27);
    @(posedge clock); #1;

    // Backpressure with ignored in_valid pulses, then a same-cycle in_valid/out_ready.
    out_ready = 1'b0;
    hold = model(8'h6B, 8'h1D, 4);
    send(4, 8'h6B, 8'h1D, 4, hold);
    for (int i = 0; i < 10; i++) begin
      iv4 = (i % 3 == 0);
      number = 8'hE0 + 8'(i); key = 8'h0F;
      check("r4_bp_out_valid", 32'(ov4), 32'd1);
      check("r4_bp_enc_stable", 32'(en4), 32'(hold));
      check("r4_bp_in_ready", 32'(ir4), 32'd0);
      @(posedge clock); #1;
    end
    iv4 = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    iv4 = 1'b0;
    check("r4_idle_after_transfer", 32'(ir4), 32'd1);
    check("r4_no_capture_in_done", 32'(b4), 32'd0);
    @(posedge clock); #1;

    // Streaming with in_valid and out_ready held high.
    cyc = 0; last = -1; idx = 0;
    iv4 = 1'b1;
    while (idx < 8 && cyc < 300) begin
      if (ir4) begin
        number = tn[idx]; key = tk[idx];
        push(4, model(tn[idx], tk[idx], 4));
        if (last >= 0) check("r4_accept_spacing", 32'(cyc - last), 32'd6);
        last = cyc;
        idx++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    iv4 = 1'b0;
    check("r4_stream_count", 32'(idx), 32'd8);
    repeat (8) @(posedge clock);
    #1;

    // Asynchronous reset in the middle of round 2 discards the transaction.
    number = 8'h3C; key = 8'hF0; iv4 = 1'b1;
    @(posedge clock); #1;
    iv4 = 1'b0;
    k = 0;
    while (ri4 != 4'd2 && k < 10) begin
      @(posedge clock); #1;
      k++;
    end
    check("r4_reached_round2", 32'(ri4), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_in_ready", 32'(ir4), 32'd1);
    check("mid_reset_out_valid", 32'(ov4), 32'd0);
    check("mid_reset_busy", 32'(b4), 32'd0);
    check("mid_reset_round_idx", 32'(ri4), 32'd0);
    check("mid_reset_enc_number", 32'(en4), 32'd0);
    check("mid_reset_enc_r1", 32'(en1), 32'd0);
    #4 reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      check("post_reset_no_out_valid", 32'(ov4), 32'd0);
      @(posedge clock); #1;
    end
    send(4, 8'hA5, 8'h5A, 4, model(8'hA5, 8'h5A, 4));
    repeat (4) @(posedge clock);
    #1;

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/enc_round_sequencer.md
# enc_round_sequencer

Multi-round sequencer for the 8-bit encryption round datapath. It accepts a plaintext byte and key through a valid/ready handshake and iterates the round function ROUNDS times. Between rounds it swaps the data halves and rotates the key left by 1. It presents the ciphertext on a valid/ready output port. It sits between the host-side byte source and the downstream sink, and it owns the only round-function instance.

## Interface
- ROUNDS, default 4: number of round iterations, legal range 1..15. Any other value is a configuration error and is not supported.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  number/key are valid this cycle.
- in_ready  output  1  sequencer can accept; high exactly when in IDLE.
- number  input  8  plaintext byte.
- key  input  8  key byte.
- out_valid  output  1  enc_number holds a completed result.
- out_ready  input  1  sink accepts result.
- enc_number  output  8  ciphertext, registered.
- busy  output  1  high in ROUND or DONE.
- round_idx  output  4  index of the round executing this cycle; 0 outside ROUND.

## Operation
- Round function R(n,k), purely combinational:
  - E = {n[3],n[0],n[1],n[2],n[1],n[3],n[2],n[0]}.
  - X = E ^ k.
  - S = (X[7:4] + X[3:0] + k[0]) mod 16. The carry-out is discarded.
  - R = {S ^ n[7:4], n[3:0]}.
- Internal registers:
  - st[7:0]: data state.
  - rk[7:0]: round key.
  - cnt[3:0]: round counter.
- FSM has three states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: st <= number, rk <= key, cnt <= 0, go to ROUND.
- ROUND: one round per clock.
  - If cnt < ROUNDS-1:
    - st <= {R[3:0], R[7:4]} (halves swapped).
    - rk <= {rk[6:0], rk[7]}.
    - cnt <= cnt+1.
  - If cnt == ROUNDS-1:
    - enc_number <= R (no swap).
    - Go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready: go to IDLE. enc_number keeps its last value.
- in_valid outside IDLE is ignored. No input is captured and there is no queueing.
- With ROUNDS=1 the result equals one pass of the single-round datapath on (number, key).

## Timing
- Reset values, applied immediately while reset is high:
  - State IDLE, so in_ready = 1.
  - out_valid = 0, busy = 0, round_idx = 0.
  - enc_number = 8'h00; st, rk, cnt = 0.
- Latency:
  - Input accepted at edge E0.
  - out_valid rises after edge E(ROUNDS), i.e. ROUNDS clocks after acceptance.
- Result handshake:
  - The result transfers at the first rising edge where out_valid && out_ready.
  - in_ready returns in the following cycle. There is no same-cycle bypass from DONE to accepting a new input.
- Throughput: at most one byte per ROUNDS+2 clocks. That minimum holds when out_ready is tied high and in_valid is held.
- Backpressure: enc_number and out_valid hold stable while out_valid && !out_ready, for any number of cycles.
- in_ready, out_valid, busy and round_idx decode directly from registered state/cnt. They have no combinational path from in_valid or out_ready.
- Reset asserted mid-ROUND or in DONE:
  - In-flight data is discarded and no out_valid pulse is produced.
  - After release, the first edge with in_valid accepts new data.
- in_valid and out_ready may be asserted in the same cycle. Only the one relevant to the current state has effect.

## Test plan
- ROUNDS=1, number=8'h46, key=8'h93:
  - out_valid rises exactly 1 clock after acceptance.
  - enc_number = 8'h06.
  - Repeat with number=8'hC9, key=8'hAC; enc_number = 8'h39.
- ROUNDS=2, number=8'h46, key=8'h93:
  - After round 0, st = 8'h60 and rk = 8'h27.
  - Final enc_number = 8'hC0, 2 clocks after acceptance.
  - round_idx shows 0 then 1.
- ROUNDS=4, out_ready held low 10 cycles after out_valid:
  - enc_number and out_valid stay constant and in_ready stays 0.
  - in_valid pulses during this window are ignored; check against a scoreboard with a reference model of R.
- ROUNDS=4, in_valid and out_ready tied high, 8 random bytes/keys:
  - Acceptances are spaced exactly 6 clocks apart.
  - All results match the reference model in order.
- Assert reset asynchronously mid-ROUND (round_idx=2) for half a cycle:
  - All outputs go to reset values immediately and no out_valid is produced.
  - The next transaction (8'hA5, 8'h5A) completes correctly.
